// File: rtl/fifo_ctrl_param_if.sv
// Handshake/status bundle for fifo_ctrl_param: producer/consumer side is master, FIFO is slave.
interface fifo_ctrl_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
);
  localparam int AW = $clog2(DEPTH);

  logic              wr;
  logic [DATA_W-1:0] wr_data;
  logic              rd;
  logic              err_clr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              rd_en;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       count;
  logic              emp;
  logic              full;
  logic              almost_emp;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr, wr_data, rd, err_clr,
    input  rd_data, wr_en, rd_en, wr_ptr, rd_ptr, count,
    input  emp, full, almost_emp, almost_full, overflow, underflow
  );

  modport slave (
    input  wr, wr_data, rd, err_clr,
    output rd_data, wr_en, rd_en, wr_ptr, rd_ptr, count,
    output emp, full, almost_emp, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_param.sv
// Parametrised single-clock FIFO with storage, occupancy count and sticky error flags.
// Define FIFO_CTRL_PARAM_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_ctrl_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic               clk,
  input logic               rst,
  fifo_ctrl_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LVL_C = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL_C = (AW+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              overflow_r;
  logic              underflow_r;
  logic [AW:0]       count_s;
  logic              emp_s;
  logic              full_s;
  logic              wr_en_s;
  logic              rd_en_s;

  // Status is derived purely from registered pointers, so a same-cycle read never frees a slot.
  assign count_s = wr_ptr_r - rd_ptr_r;
  assign emp_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) & (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign wr_en_s = bus.wr & ~full_s & ~rst;
  assign rd_en_s = bus.rd & ~emp_s & ~rst;

  assign bus.wr_en       = wr_en_s;
  assign bus.rd_en       = rd_en_s;
  assign bus.wr_ptr      = wr_ptr_r;
  assign bus.rd_ptr      = rd_ptr_r;
  assign bus.count       = count_s;
  assign bus.emp         = emp_s;
  assign bus.full        = full_s;
  assign bus.almost_full = (count_s >= AF_LVL_C);
  assign bus.almost_emp  = (count_s <= AE_LVL_C);
  assign bus.overflow    = overflow_r;
  assign bus.underflow   = underflow_r;

  // Pointer advance; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= bus.wr_data;
  end

  // Sticky error flags: a new error in the same cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.wr & full_s)      overflow_r <= 1'b1;
      else if (bus.err_clr)     overflow_r <= 1'b0;
      else                      overflow_r <= overflow_r;
      if (bus.rd & emp_s)       underflow_r <= 1'b1;
      else if (bus.err_clr)     underflow_r <= 1'b0;
      else                      underflow_r <= underflow_r;
    end
  end

`ifdef FIFO_CTRL_PARAM_FWFT_EN
  // Head word is always presented; rd only acknowledges it.
  assign bus.rd_data = mem_r[rd_ptr_r[AW-1:0]];
`else
  logic [DATA_W-1:0] rd_data_r;

  // Registered read port holds the last popped word until the next accepted read.
  always_ff @(posedge clk) begin
    if (rst)          rd_data_r <= '0;
    else if (rd_en_s) rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
    else              rd_data_r <= rd_data_r;
  end

  assign bus.rd_data = rd_data_r;
`endif
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Randomised + directed bench for fifo_ctrl_param against a queue-based reference model.
module tb_fifo_ctrl_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_ctrl_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_ctrl_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: contents as a queue, pointers as operation totals.
  logic [DATA_W-1:0] q[$];
  int                wr_total;
  int                rd_total;
  bit                ovf_m;
  bit                unf_m;
  logic [DATA_W-1:0] last_rd_m;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    check_val("count",       32'(bus.count),       32'(n));
    check_val("emp",         32'(bus.emp),         32'(n == 0));
    check_val("full",        32'(bus.full),        32'(n == DEPTH));
    check_val("almost_full", 32'(bus.almost_full), 32'(n >= AF));
    check_val("almost_emp",  32'(bus.almost_emp),  32'(n <= AE));
    check_val("wr_ptr",      32'(bus.wr_ptr),      32'(wr_total % (2*DEPTH)));
    check_val("rd_ptr",      32'(bus.rd_ptr),      32'(rd_total % (2*DEPTH)));
    check_val("overflow",    32'(bus.overflow),    32'(ovf_m));
    check_val("underflow",   32'(bus.underflow),   32'(unf_m));
`ifdef FIFO_CTRL_PARAM_FWFT_EN
    if (n != 0) check_val("rd_data_head", 32'(bus.rd_data), 32'(q[0]));
`else
    check_val("rd_data", 32'(bus.rd_data), 32'(last_rd_m));
`endif
  endtask

  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic r,
                      input logic c, input logic rs);
    bit was_full;
    bit was_emp;
    bit acc_w;
    bit acc_r;
    bus.wr      = w;
    bus.wr_data = d;
    bus.rd      = r;
    bus.err_clr = c;
    rst         = rs;
    was_full = (q.size() == DEPTH);
    was_emp  = (q.size() == 0);
    acc_w    = w && !was_full && !rs;
    acc_r    = r && !was_emp && !rs;
    #1;
    check_val("wr_en", 32'(bus.wr_en), 32'(acc_w));
    check_val("rd_en", 32'(bus.rd_en), 32'(acc_r));
    @(posedge clk);
    if (rs) begin
      q.delete();
      wr_total  = 0;
      rd_total  = 0;
      ovf_m     = 1'b0;
      unf_m     = 1'b0;
      last_rd_m = '0;
    end else begin
      if (acc_r) begin
        last_rd_m = q.pop_front();
        rd_total++;
      end
      if (acc_w) begin
        q.push_back(d);
        wr_total++;
      end
      if (w && was_full) ovf_m = 1'b1;
      else if (c)        ovf_m = 1'b0;
      if (r && was_emp)  unf_m = 1'b1;
      else if (c)        unf_m = 1'b0;
    end
    #1;
    check_state();
  endtask

  initial begin
    rst = 1'b1;
    bus.wr = 1'b0; bus.wr_data = '0; bus.rd = 1'b0; bus.err_clr = 1'b0;
    q.delete(); wr_total = 0; rd_total = 0; ovf_m = 1'b0; unf_m = 1'b0; last_rd_m = '0;
    @(posedge clk); #1;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Fill past full with 0x00..0x21.
    for (int i = 0; i < 34; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    // Drain past empty.
    for (int i = 0; i < 34; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Steady simultaneous traffic at count=5 across pointer wrap.
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);

    // At full with wr and rd together, then clear the error.
    while (q.size() < DEPTH) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset during a read burst.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Single word with no read (head visibility in FWFT), then pop it.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random traffic with drifting write/read bias so both ends get exercised.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 300) % 2 == 0) ? 70 : 30;
      step(logic'($urandom_range(0, 99) < wp),
           8'($urandom_range(0, 255)),
           logic'($urandom_range(0, 99) < (100 - wp)),
           logic'($urandom_range(0, 19) == 0),
           logic'($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
